// File: rtl/dmac_pkg.sv
// dmac_pkg: shared AHB transfer-type encodings and DMA counter widths
package dmac_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        NON_SEQ = 2'b10,
        SEQ     = 2'b11
    } htrans_t;
    localparam int DMAC_TSZ_W = 16;
    localparam int DMAC_BLEN_W = 5;
    localparam logic [DMAC_BLEN_W-1:0] DMAC_MAX_BURST = 5'd16;
endpackage

// File: rtl/dmac_xfer_counter.sv
// dmac_xfer_counter: per-channel beat/burst/remaining-transfer counter with status flags
//   clk, rst                  clock, synchronous active-high reset
//   transfer_size, burst_len  programmed totals; t_sel+sz_en loads them
//   burst_en, b_sel           burst-length load (0: min(burst, size), 1: remaining)
//   count_en, HTrans, write   one issued beat, its transfer type and phase
//   bsz, tslb, tsz            burst done, short tail, transfer done
//   remaining, beat_cnt       write beats left, beats in current phase
//   cfg_err                   sticky bad burst length / underflow
module dmac_xfer_counter
    import dmac_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DMAC_TSZ_W-1:0]  transfer_size,
    input  logic [DMAC_BLEN_W-1:0] burst_len,
    input  logic                   t_sel,
    input  logic                   sz_en,
    input  logic                   burst_en,
    input  logic                   b_sel,
    input  logic                   count_en,
    input  logic [1:0]             HTrans,
    input  logic                   write,
    output logic                   bsz,
    output logic                   tslb,
    output logic                   tsz,
    output logic [DMAC_TSZ_W-1:0]  remaining,
    output logic [DMAC_BLEN_W-1:0] beat_cnt,
    output logic                   cfg_err
);
    localparam int PAD = DMAC_TSZ_W - DMAC_BLEN_W;
    logic [DMAC_TSZ_W-1:0]  rem_r;
    logic [DMAC_BLEN_W-1:0] burst_cfg_r, blen_r, beat_r;
    logic                   err_r;
    logic                   load, bad_len, nseq, seq, dec;
    logic [DMAC_BLEN_W-1:0] blen_clamp, blen_min;
    always_comb begin
        load       = sz_en && t_sel;
        bad_len    = burst_len == '0 || burst_len > DMAC_MAX_BURST;
        blen_clamp = burst_len == '0 ? 5'd1 : burst_len > DMAC_MAX_BURST ? DMAC_MAX_BURST : burst_len;
        // Taken from the inputs so a burst load can share the cycle with sz_en
        blen_min   = transfer_size < {{PAD{1'b0}}, blen_clamp} ? transfer_size[DMAC_BLEN_W-1:0] : blen_clamp;
        nseq       = count_en && HTrans == NON_SEQ;
        seq        = count_en && HTrans == SEQ;
        dec        = (nseq || seq) && write;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r       <= '0;
            burst_cfg_r <= '0;
            blen_r      <= '0;
            beat_r      <= '0;
            err_r       <= 1'b0;
        end else begin
            if (load) begin
                rem_r       <= transfer_size;
                burst_cfg_r <= blen_clamp;
                beat_r      <= '0;
                err_r       <= bad_len;
            end else begin
                if (nseq)
                    beat_r <= 5'd1;
                else if (seq && beat_r != DMAC_MAX_BURST)
                    beat_r <= beat_r + 5'd1;
                if (dec) begin
                    if (rem_r == '0)
                        err_r <= 1'b1;
                    else
                        rem_r <= rem_r - 16'd1;
                end
            end
            // b_sel is only used once tslb holds, so rem_r fits the burst width
            if (burst_en)
                blen_r <= b_sel ? rem_r[DMAC_BLEN_W-1:0] : blen_min;
        end
    end
    assign bsz       = beat_r == blen_r && blen_r != '0;
    assign tsz       = rem_r == '0;
    assign tslb      = rem_r != '0 && rem_r < {{PAD{1'b0}}, burst_cfg_r};
    assign remaining = rem_r;
    assign beat_cnt  = beat_r;
    assign cfg_err   = err_r;
endmodule

// File: tb/tb_dmac_xfer_counter.sv
// tb_dmac_xfer_counter: directed self-checking bench for dmac_xfer_counter
module tb_dmac_xfer_counter;
    import dmac_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] transfer_size = '0;
    logic [4:0]  burst_len = '0;
    logic        t_sel = 1'b0, sz_en = 1'b0, burst_en = 1'b0, b_sel = 1'b0;
    logic        count_en = 1'b0, write = 1'b0;
    logic [1:0]  HTrans = 2'b00;
    logic        bsz, tslb, tsz, cfg_err;
    logic [15:0] remaining;
    logic [4:0]  beat_cnt;
    int          checks = 0;
    int          passes = 0;

    dmac_xfer_counter dut (
        .clk(clk), .rst(rst), .transfer_size(transfer_size), .burst_len(burst_len),
        .t_sel(t_sel), .sz_en(sz_en), .burst_en(burst_en), .b_sel(b_sel),
        .count_en(count_en), .HTrans(HTrans), .write(write),
        .bsz(bsz), .tslb(tslb), .tsz(tsz), .remaining(remaining),
        .beat_cnt(beat_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic sz, input logic be, input logic bs, input logic ce,
                       input logic [1:0] ht, input logic wr);
        sz_en = sz; t_sel = sz; burst_en = be; b_sel = bs;
        count_en = ce; HTrans = ht; write = wr;
        @(posedge clk);
        #1;
        sz_en = 1'b0; t_sel = 1'b0; burst_en = 1'b0; b_sel = 1'b0;
        count_en = 1'b0; HTrans = 2'b00; write = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".tsz"}, 16'(tsz), 16'd1);
        check({tag, ".bsz"}, 16'(bsz), 16'd0);
        check({tag, ".tslb"}, 16'(tslb), 16'd0);
        check({tag, ".remaining"}, remaining, 16'd0);
        check({tag, ".beat_cnt"}, 16'(beat_cnt), 16'd0);
        check({tag, ".cfg_err"}, 16'(cfg_err), 16'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("reset");
        transfer_size = 16'd8; burst_len = 5'd4;
        cyc(1, 1, 0, 0, IDLE, 0);
        check("s1.load.remaining", remaining, 16'd8);
        check("s1.load.bsz", 16'(bsz), 16'd0);
        check("s1.load.tsz", 16'(tsz), 16'd0);
        cyc(0, 0, 0, 1, NON_SEQ, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, SEQ, 0);
        check("s1.rd.bsz", 16'(bsz), 16'd1);
        check("s1.rd.beat_cnt", 16'(beat_cnt), 16'd4);
        check("s1.rd.remaining", remaining, 16'd8);
        cyc(0, 0, 0, 1, NON_SEQ, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, SEQ, 1);
        check("s1.wr.remaining", remaining, 16'd4);
        check("s1.wr.bsz", 16'(bsz), 16'd1);
        check("s1.wr.tsz", 16'(tsz), 16'd0);
        check("s1.wr.tslb", 16'(tslb), 16'd0);
        cyc(0, 0, 0, 1, NON_SEQ, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, SEQ, 1);
        check("s1.wr2.remaining", remaining, 16'd0);
        check("s1.wr2.tsz", 16'(tsz), 16'd1);
        check("s1.wr2.bsz", 16'(bsz), 16'd1);

        transfer_size = 16'd6; burst_len = 5'd4;
        cyc(1, 1, 0, 0, IDLE, 0);
        cyc(0, 0, 0, 1, NON_SEQ, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, SEQ, 1);
        check("s2.remaining", remaining, 16'd2);
        check("s2.tslb", 16'(tslb), 16'd1);
        cyc(0, 1, 1, 1, NON_SEQ, 0);
        check("s2.tail1.beat_cnt", 16'(beat_cnt), 16'd1);
        check("s2.tail1.bsz", 16'(bsz), 16'd0);
        cyc(0, 0, 0, 1, SEQ, 0);
        check("s2.tail2.beat_cnt", 16'(beat_cnt), 16'd2);
        check("s2.tail2.bsz", 16'(bsz), 16'd1);

        transfer_size = 16'd3; burst_len = 5'd8;
        cyc(1, 1, 0, 0, IDLE, 0);
        check("s3.tslb", 16'(tslb), 16'd1);
        cyc(0, 0, 0, 1, NON_SEQ, 1);
        cyc(0, 0, 0, 1, SEQ, 1);
        check("s3.beat2.bsz", 16'(bsz), 16'd0);
        cyc(0, 0, 0, 1, SEQ, 1);
        check("s3.beat3.bsz", 16'(bsz), 16'd1);
        check("s3.beat3.tsz", 16'(tsz), 16'd1);
        check("s3.cfg_err", 16'(cfg_err), 16'd0);

        transfer_size = 16'd0; burst_len = 5'd4;
        cyc(1, 0, 0, 0, IDLE, 0);
        check("s4.zero.tsz", 16'(tsz), 16'd1);
        check("s4.zero.cfg_err", 16'(cfg_err), 16'd0);
        cyc(0, 0, 0, 1, SEQ, 1);
        check("s4.under.remaining", remaining, 16'd0);
        check("s4.under.cfg_err", 16'(cfg_err), 16'd1);
        cyc(0, 0, 0, 1, BUSY, 1);
        check("s4.busy.beat_cnt", 16'(beat_cnt), 16'd1);
        transfer_size = 16'd9;
        cyc(1, 0, 0, 1, NON_SEQ, 1);
        check("s4.prio.remaining", remaining, 16'd9);
        check("s4.prio.beat_cnt", 16'(beat_cnt), 16'd0);
        check("s4.prio.cfg_err", 16'(cfg_err), 16'd0);

        transfer_size = 16'd10; burst_len = 5'd0;
        cyc(1, 1, 0, 0, IDLE, 0);
        check("s5.bl0.cfg_err", 16'(cfg_err), 16'd1);
        cyc(0, 0, 0, 1, NON_SEQ, 0);
        check("s5.bl0.bsz", 16'(bsz), 16'd1);
        check("s5.bl0.tslb", 16'(tslb), 16'd0);
        transfer_size = 16'd16; burst_len = 5'd20;
        cyc(1, 1, 0, 0, IDLE, 0);
        check("s5.bl20.cfg_err", 16'(cfg_err), 16'd1);
        check("s5.bl20.tslb", 16'(tslb), 16'd0);
        cyc(0, 0, 0, 1, NON_SEQ, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, SEQ, 0);
        check("s5.sat.beat_cnt", 16'(beat_cnt), 16'd16);
        check("s5.sat.bsz", 16'(bsz), 16'd1);
        rst = 1'b1;
        cyc(0, 1, 0, 1, SEQ, 1);
        rst = 1'b0;
        check_reset("s5.rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
